frame_update_sequencer: RTL and testbench

Per-frame scheduler for the game-object datapath.
- On every vertical-sync frame boundary, it grants update slots to the object blocks (player, hecatia, moon, laser) one at a time in a fixed order, using a req/done handshake.
- After all objects have updated, it triggers the collision/hit judges.
- It sits between the VGA controller's vsync output, the FSM's game_en, and the object/judge blocks. It replaces free-running per-object update counters, so every object moves exactly once per scheduled frame.

---
 rtl/stg_pkg.sv | 18 +
 rtl/frame_update_sequencer_if.sv | 27 ++
 rtl/vsync_edge_sync.sv | 34 +++
 rtl/frame_update_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_frame_update_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stg_pkg.sv
// Shared types and constants for the frame update sequencer.
package stg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPD,
    JUDGE,
    DONE
  } stg_state_e;

  // Fixed update order: the object index is its slot in each frame.
  localparam int unsigned OBJ_PLAYER    = 0;
  localparam int unsigned OBJ_HECATIA   = 1;
  localparam int unsigned OBJ_MOON      = 2;
  localparam int unsigned OBJ_LASER     = 3;
  localparam int unsigned N_OBJ_DEFAULT = 4;

endpackage

// File: rtl/frame_update_sequencer_if.sv
// Request/done handshake between the sequencer and the object/judge blocks.
interface frame_update_sequencer_if
  import stg_pkg::*;
#(
  parameter int unsigned N_OBJ = N_OBJ_DEFAULT
) ();

  logic [N_OBJ-1:0] upd_req;
  logic [N_OBJ-1:0] upd_done;
  logic             judge_req;
  logic             judge_done;

  modport master (
    output upd_req,
    output judge_req,
    input  upd_done,
    input  judge_done
  );

  modport slave (
    input  upd_req,
    input  judge_req,
    output upd_done,
    output judge_done
  );

endinterface

// File: rtl/vsync_edge_sync.sv
// Brings the asynchronous active-low vsync into the clk domain and turns its
// falling edge into a single-cycle frame tick.
module vsync_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic vsync,
  output logic frame_tick,
  output logic vsync_sync
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser plus one delayed copy for edge detection; idle level is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= vsync;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Falling edge of the synchronised level.
  always_comb begin
    vsync_sync = sync2_q;
    frame_tick = prev_q & ~sync2_q;
  end

endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame scheduler: on each (divided) vsync tick, grants one update slot to
// each object in fixed order, then runs the judges, then counts the frame.
module frame_update_sequencer
  import stg_pkg::*;
#(
  parameter int unsigned N_OBJ     = N_OBJ_DEFAULT,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             vsync,
  input  logic                             game_en,
  input  logic                             pause,
  input  logic                             err_clr,
  frame_update_sequencer_if.master         bus,
  output logic                             busy,
  output logic [15:0]                      frame_cnt,
  output logic                             overrun,
  output logic                             timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam int unsigned IdxW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(N_OBJ - 1);
  localparam logic [7:0]      DivLast    = 8'(FRAME_DIV - 1);

  logic frame_tick;
  logic vsync_level;

  vsync_edge_sync u_vsync_edge_sync (
    .clk        (clk),
    .rstn       (rstn),
    .vsync      (vsync),
    .frame_tick (frame_tick),
    .vsync_sync (vsync_level)
  );

  stg_state_e       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       div_q, div_d;
  logic             armed_q, armed_d;
  logic [N_OBJ-1:0] upd_req_q, upd_req_d;
  logic             judge_req_q, judge_req_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  logic             done_cur;
  logic [CntW-1:0]  cnt_inc;
  logic             timeout_hit;
  logic             phase_end;

  // Phase completion: done only counts once it has been seen low in this phase.
  always_comb begin
    done_cur = 1'b0;
    if (state_q == UPD) begin
      done_cur = bus.upd_done[idx_q];
    end else if (state_q == JUDGE) begin
      done_cur = bus.judge_done;
    end
    cnt_inc     = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + CntW'(1);
    timeout_hit = ((state_q == UPD) || (state_q == JUDGE)) && (cnt_inc == TimeoutVal);
    phase_end   = (armed_q && done_cur) || timeout_hit;
  end

  // Next-state, divider, counters and sticky flags.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_inc;
    div_d         = div_q;
    armed_d       = armed_q | ~done_cur;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;

    // Clear first so a coinciding set condition below wins.
    if (err_clr) begin
      overrun_d     = 1'b0;
      timeout_err_d = 1'b0;
    end
    if (frame_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        idx_d   = '0;
        cnt_d   = '0;
        armed_d = 1'b0;
        if (frame_tick) begin
          if (div_q == DivLast) begin
            div_d = 8'd0;
            if (game_en && !pause) begin
              state_d = UPD;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      UPD: begin
        if (!game_en) begin
          state_d = IDLE;
          idx_d   = '0;
          div_d   = 8'd0;
        end else if (phase_end) begin
          cnt_d   = '0;
          armed_d = 1'b0;
          if (timeout_hit) begin
            timeout_err_d = 1'b1;
          end
          if (idx_q == LastIdx) begin
            state_d = JUDGE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      JUDGE: begin
        if (!game_en) begin
          state_d = IDLE;
          idx_d   = '0;
          div_d   = 8'd0;
        end else if (phase_end) begin
          cnt_d   = '0;
          armed_d = 1'b0;
          state_d = DONE;
          if (timeout_hit) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
        idx_d       = '0;
        cnt_d       = '0;
        armed_d     = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Grants are decoded from the next state so they are registered outputs.
    upd_req_d = '0;
    if (state_d == UPD) begin
      upd_req_d[idx_d] = 1'b1;
    end
    judge_req_d = (state_d == JUDGE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      div_q         <= 8'd0;
      armed_q       <= 1'b0;
      upd_req_q     <= '0;
      judge_req_q   <= 1'b0;
      frame_cnt_q   <= 16'd0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      armed_q       <= armed_d;
      upd_req_q     <= upd_req_d;
      judge_req_q   <= judge_req_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.upd_req   = upd_req_q;
    bus.judge_req = judge_req_q;
    busy          = (state_q != IDLE);
    frame_cnt     = frame_cnt_q;
    overrun       = overrun_q;
    timeout_err   = timeout_err_q;
  end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Directed bench: a cycle table for the basic sequence plus hand-written
// sequences for division, timeout, overrun, abort, async reset and held done.
module tb_frame_update_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vsync;
  logic        game_en;
  logic        pause;
  logic        err_clr;
  logic        busy1, busy3;
  logic [15:0] frame_cnt1, frame_cnt3;
  logic        overrun1, overrun3;
  logic        timeout_err1, timeout_err3;

  // Responder controls shared by both DUT-side models.
  logic [3:0]  mask;
  logic        jen;
  logic        manual;
  logic [3:0]  man_done;
  logic [3:0]  prev1, prev3;
  logic        prevj1, prevj3;

  int checks = 0;
  int errors = 0;

  frame_update_sequencer_if #(.N_OBJ(4)) bus1 ();
  frame_update_sequencer_if #(.N_OBJ(4)) bus3 ();

  frame_update_sequencer #(.N_OBJ(4), .FRAME_DIV(1), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .vsync       (vsync),
    .game_en     (game_en),
    .pause       (pause),
    .err_clr     (err_clr),
    .bus         (bus1),
    .busy        (busy1),
    .frame_cnt   (frame_cnt1),
    .overrun     (overrun1),
    .timeout_err (timeout_err1)
  );

  frame_update_sequencer #(.N_OBJ(4), .FRAME_DIV(3), .TIMEOUT(15)) dut3 (
    .clk         (clk),
    .rstn        (rstn),
    .vsync       (vsync),
    .game_en     (game_en),
    .pause       (pause),
    .err_clr     (err_clr),
    .bus         (bus3),
    .busy        (busy3),
    .frame_cnt   (frame_cnt3),
    .overrun     (overrun3),
    .timeout_err (timeout_err3)
  );

  always #5 clk = ~clk;

  // Object/judge models: each done echoes its request one cycle late.
  always @(negedge clk) begin
    bus1.upd_done   = manual ? man_done : (prev1 & mask);
    prev1           = bus1.upd_req;
    bus1.judge_done = prevj1 & jen;
    prevj1          = bus1.judge_req;
    bus3.upd_done   = prev3 & mask;
    prev3           = bus3.upd_req;
    bus3.judge_done = prevj3 & jen;
    prevj3          = bus3.judge_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        vsync;
    logic [3:0]  exp_req;
    logic        exp_jreq;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // which: 0 = upd_req equals v, 1 = judge_req high, other = busy low.
  task automatic wait_for(input int which, input logic [3:0] v, input int bound,
                          input string name);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(posedge clk);
      #1;
      case (which)
        0:       hit = (bus1.upd_req == v);
        1:       hit = (bus1.judge_req == 1'b1);
        default: hit = (busy1 == 1'b0);
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: got no event within %0d cycles, want event", name, bound);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Two-cycle low pulse; returns just before the edge that raises upd_req[0].
  task automatic vsync_fall();
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
  endtask

  initial begin
    int n;
    rstn     = 1'b0;
    vsync    = 1'b1;
    game_en  = 1'b1;
    pause    = 1'b0;
    err_clr  = 1'b0;
    mask     = 4'b1111;
    jen      = 1'b1;
    manual   = 1'b0;
    man_done = 4'b0000;
    prev1    = 4'b0000;
    prev3    = 4'b0000;
    prevj1   = 1'b0;
    prevj3   = 1'b0;

    //             vsync  upd_req  jreq  busy  frame_cnt
    tv[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 16'd0};
    tv[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 16'd0};
    tv[2]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 16'd0};
    tv[3]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 16'd0};
    tv[4]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 16'd0};
    tv[5]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 16'd0};
    tv[6]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 16'd0};
    tv[7]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 16'd0};
    tv[8]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 16'd0};
    tv[9]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 16'd0};
    tv[10] = '{1'b1, 4'b0000, 1'b1, 1'b1, 16'd0};
    tv[11] = '{1'b1, 4'b0000, 1'b1, 1'b1, 16'd0};
    tv[12] = '{1'b1, 4'b0000, 1'b0, 1'b1, 16'd0};
    tv[13] = '{1'b1, 4'b0000, 1'b0, 1'b0, 16'd1};

    // Reset state.
    do_reset();
    chk("reset upd_req", 32'(bus1.upd_req), 32'h0);
    chk("reset judge_req", 32'(bus1.judge_req), 32'h0);
    chk("reset busy", 32'(busy1), 32'h0);
    chk("reset frame_cnt", 32'(frame_cnt1), 32'h0);
    chk("reset overrun", 32'(overrun1), 32'h0);
    chk("reset timeout_err", 32'(timeout_err1), 32'h0);

    // 1: single frame, cycle-exact trace.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      vsync = tv[i].vsync;
      @(posedge clk);
      #1;
      chk($sformatf("t1 row%0d upd_req", i), 32'(bus1.upd_req), 32'(tv[i].exp_req));
      chk($sformatf("t1 row%0d judge_req", i), 32'(bus1.judge_req), 32'(tv[i].exp_jreq));
      chk($sformatf("t1 row%0d busy", i), 32'(busy1), 32'(tv[i].exp_busy));
      chk($sformatf("t1 row%0d frame_cnt", i), 32'(frame_cnt1), 32'(tv[i].exp_cnt));
    end

    // 2: divide-by-3 runs only on ticks 3 and 6.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vsync_fall();
      repeat (30) @(posedge clk);
      #1;
      chk($sformatf("t2 tick%0d div3 frame_cnt", i + 1), 32'(frame_cnt3), 32'((i + 1) / 3));
      chk($sformatf("t2 tick%0d div1 frame_cnt", i + 1), 32'(frame_cnt1), 32'(i + 1));
    end
    chk("t2 div3 busy", 32'(busy3), 32'h0);

    // 3: object 2 never answers; its slot times out after 15 cycles.
    do_reset();
    mask = 4'b1011;
    vsync_fall();
    wait_for(0, 4'b0100, 30, "t3 reach upd_req[2]");
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus1.upd_req != 4'b0100) break;
      n++;
    end
    chk("t3 upd_req[2] high cycles", 32'(n), 32'd15);
    chk("t3 next req", 32'(bus1.upd_req), 32'b1000);
    chk("t3 timeout_err", 32'(timeout_err1), 32'h1);
    wait_for(2, 4'b0000, 30, "t3 back to idle");
    chk("t3 frame_cnt", 32'(frame_cnt1), 32'h1);
    mask = 4'b1111;

    // 4: tick during JUDGE sets overrun and is dropped; err_clr clears.
    do_reset();
    jen = 1'b0;
    vsync_fall();
    wait_for(1, 4'b0000, 30, "t4 reach judge");
    vsync_fall();
    wait_for(2, 4'b0000, 40, "t4 back to idle");
    chk("t4 overrun", 32'(overrun1), 32'h1);
    chk("t4 frame_cnt", 32'(frame_cnt1), 32'h1);
    repeat (30) @(posedge clk);
    #1;
    chk("t4 no queued sequence busy", 32'(busy1), 32'h0);
    chk("t4 no queued sequence cnt", 32'(frame_cnt1), 32'h1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4 overrun cleared", 32'(overrun1), 32'h0);
    chk("t4 timeout_err cleared", 32'(timeout_err1), 32'h0);
    jen = 1'b1;

    // 5: game_en drop aborts, next tick restarts at index 0.
    do_reset();
    vsync_fall();
    wait_for(0, 4'b0010, 20, "t5 reach upd_req[1]");
    @(negedge clk);
    game_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t5 abort upd_req", 32'(bus1.upd_req), 32'h0);
    chk("t5 abort judge_req", 32'(bus1.judge_req), 32'h0);
    chk("t5 abort busy", 32'(busy1), 32'h0);
    chk("t5 abort frame_cnt", 32'(frame_cnt1), 32'h0);
    @(negedge clk);
    game_en = 1'b1;
    vsync_fall();
    wait_for(0, 4'b0001, 10, "t5 restart at index 0");
    wait_for(2, 4'b0000, 40, "t5 back to idle");
    chk("t5 frame_cnt after restart", 32'(frame_cnt1), 32'h1);

    // 6a: asynchronous reset in the middle of an update phase.
    vsync_fall();
    wait_for(0, 4'b0001, 10, "t6 reach upd_req[0]");
    #2;
    rstn = 1'b0;
    #1;
    chk("t6 async upd_req", 32'(bus1.upd_req), 32'h0);
    chk("t6 async busy", 32'(busy1), 32'h0);
    chk("t6 async frame_cnt", 32'(frame_cnt1), 32'h0);
    chk("t6 async overrun", 32'(overrun1), 32'h0);
    chk("t6 async timeout_err", 32'(timeout_err1), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 6b: done held high across a phase change does not complete the next phase.
    manual   = 1'b1;
    man_done = 4'b0000;
    vsync_fall();
    wait_for(0, 4'b0001, 10, "t6 held reach upd_req[0]");
    @(posedge clk);
    @(negedge clk);
    man_done = 4'b0011;
    @(posedge clk);
    #1;
    chk("t6 held phase0 done", 32'(bus1.upd_req), 32'b0010);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t6 held phase1 stays %0d", i), 32'(bus1.upd_req), 32'b0010);
    end
    @(negedge clk);
    man_done = 4'b0001;
    @(posedge clk);
    #1;
    chk("t6 phase1 armed not done", 32'(bus1.upd_req), 32'b0010);
    @(negedge clk);
    man_done = 4'b0011;
    @(posedge clk);
    #1;
    chk("t6 phase1 own edge done", 32'(bus1.upd_req), 32'b0100);
    @(negedge clk);
    manual = 1'b0;
    wait_for(2, 4'b0000, 40, "t6 back to idle");
    chk("t6 frame_cnt", 32'(frame_cnt1), 32'h1);
    chk("t6 timeout_err", 32'(timeout_err1), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
